// File: rtl/rv32_pipe_pkg.sv
// Shared constants and pipeline-register payload types for the RV32I fetch/decode/execute register slice.
package rv32_pipe_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CTRL_W = 10;

   localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

   // Control bundle, MSB first: RegWrite is bit 9 and ALUSrc is bit 0.
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic [2:0] alu_control;
      logic       alu_src;
   } ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } ifid_t;

   typedef struct packed {
      ctrl_t            ctrl;
      logic [XLEN-1:0]  rd1;
      logic [XLEN-1:0]  rd2;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  pc_plus4;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic             valid;
   } idex_t;

   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/pipe_fd_regs_if.sv
// Hazard-control, fetch/decode and execute-side signals of pipe_fd_regs.
// The perf-counter outputs exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_fd_regs_if;
   import rv32_pipe_pkg::*;

   logic                StallF;
   logic                StallD;
   logic                FlushD;
   logic                FlushE;
   logic                PCSrcE;
   logic [XLEN-1:0]     PCTargetE;
   logic [XLEN-1:0]     InstrF;
   logic [XLEN-1:0]     PCF;
   logic [XLEN-1:0]     InstrD;
   logic [XLEN-1:0]     PCD;
   logic [XLEN-1:0]     PCPlus4D;
   logic                ValidD;
   logic [CTRL_W-1:0]   CtrlD;
   logic [XLEN-1:0]     RD1D;
   logic [XLEN-1:0]     RD2D;
   logic [XLEN-1:0]     ImmExtD;
   logic [REG_W-1:0]    Rs1D;
   logic [REG_W-1:0]    Rs2D;
   logic [REG_W-1:0]    RdD;
   logic [CTRL_W-1:0]   CtrlE;
   logic [XLEN-1:0]     RD1E;
   logic [XLEN-1:0]     RD2E;
   logic [XLEN-1:0]     ImmExtE;
   logic [XLEN-1:0]     PCE;
   logic [XLEN-1:0]     PCPlus4E;
   logic [REG_W-1:0]    Rs1E;
   logic [REG_W-1:0]    Rs2E;
   logic [REG_W-1:0]    RdE;
   logic                ValidE;
`ifdef PIPE_PERF_CNT_EN
   logic [XLEN-1:0]     stall_cnt;
   logic [XLEN-1:0]     flush_cnt;
   logic [XLEN-1:0]     retire_cnt;
`endif

   modport master (
      output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
             CtrlD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
      input  PCF, InstrD, PCD, PCPlus4D, ValidD,
             CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE
`ifdef PIPE_PERF_CNT_EN
      , input stall_cnt, flush_cnt, retire_cnt
`endif
   );

   modport slave (
      input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
             CtrlD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
      output PCF, InstrD, PCD, PCPlus4D, ValidD,
             CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE
`ifdef PIPE_PERF_CNT_EN
      , output stall_cnt, flush_cnt, retire_cnt
`endif
   );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: async reset to RST_VAL, synchronous clear to CLR_VAL (clear beats enable).
module pipe_reg #(
   parameter int unsigned  W       = 32,
   parameter logic [W-1:0] RST_VAL = '0,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] state_d;
   logic [W-1:0] state_q;

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = CLR_VAL;
      end else if (en) begin
         state_d = d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RST_VAL;
      end else begin
         state_q <= state_d;
      end
   end

   assign q = state_q;

endmodule

// File: rtl/pipe_fd_regs.sv
// PC, IF/ID and ID/EX registers driven by the hazard unit's stall/flush controls.
// Optional perf counters (stall/flush/retire) are built when PIPE_PERF_CNT_EN is defined.
module pipe_fd_regs
   import rv32_pipe_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic          clk,
   input  logic          rst,
   pipe_fd_regs_if.slave bus
);

   localparam ifid_t IFID_IDLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4_f;
   logic            pc_en;
   ifid_t           ifid_d;
   ifid_t           ifid_q;
   idex_t           idex_d;
   idex_t           idex_q;

   // A redirect must land even while fetch is stalled.
   always_comb begin
      pc_plus4_f = pc_inc(pc_q);
      pc_d       = bus.PCSrcE ? bus.PCTargetE : pc_plus4_f;
      pc_en      = ~bus.StallF | bus.PCSrcE;
      ifid_d     = '{instr: bus.InstrF, pc: pc_q, pc_plus4: pc_plus4_f, valid: 1'b1};
      idex_d     = '{ctrl:     ctrl_t'(bus.CtrlD),
                     rd1:      bus.RD1D,
                     rd2:      bus.RD2D,
                     imm:      bus.ImmExtD,
                     pc:       ifid_q.pc,
                     pc_plus4: ifid_q.pc_plus4,
                     rs1:      bus.Rs1D,
                     rs2:      bus.Rs2D,
                     rd:       bus.RdD,
                     valid:    ifid_q.valid};
   end

   pipe_reg #(.W(XLEN), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) u_pc (
      .clk (clk),
      .rst (rst),
      .en  (pc_en),
      .clr (1'b0),
      .d   (pc_d),
      .q   (pc_q)
   );

   pipe_reg #(.W($bits(ifid_t)), .RST_VAL(IFID_IDLE), .CLR_VAL(IFID_IDLE)) u_ifid (
      .clk (clk),
      .rst (rst),
      .en  (~bus.StallD),
      .clr (bus.FlushD),
      .d   (ifid_d),
      .q   (ifid_q)
   );

   // A flushed ID/EX is all-zero, so ResultSrcE reads as "not a load".
   pipe_reg #(.W($bits(idex_t)), .RST_VAL('0), .CLR_VAL('0)) u_idex (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .clr (bus.FlushE),
      .d   (idex_d),
      .q   (idex_q)
   );

   assign bus.PCF      = pc_q;
   assign bus.InstrD   = ifid_q.instr;
   assign bus.PCD      = ifid_q.pc;
   assign bus.PCPlus4D = ifid_q.pc_plus4;
   assign bus.ValidD   = ifid_q.valid;
   assign bus.CtrlE    = idex_q.ctrl;
   assign bus.RD1E     = idex_q.rd1;
   assign bus.RD2E     = idex_q.rd2;
   assign bus.ImmExtE  = idex_q.imm;
   assign bus.PCE      = idex_q.pc;
   assign bus.PCPlus4E = idex_q.pc_plus4;
   assign bus.Rs1E     = idex_q.rs1;
   assign bus.Rs2E     = idex_q.rs2;
   assign bus.RdE      = idex_q.rd;
   assign bus.ValidE   = idex_q.valid;

`ifdef PIPE_PERF_CNT_EN
   logic [XLEN-1:0] stall_cnt_d;
   logic [XLEN-1:0] stall_cnt_q;
   logic [XLEN-1:0] flush_cnt_d;
   logic [XLEN-1:0] flush_cnt_q;
   logic [XLEN-1:0] retire_cnt_d;
   logic [XLEN-1:0] retire_cnt_q;

   // flush_cnt excludes load-use bubbles (FlushE with StallD) to count branch bubbles only.
   always_comb begin
      stall_cnt_d  = stall_cnt_q + XLEN'(bus.StallD);
      flush_cnt_d  = flush_cnt_q + XLEN'(bus.FlushE & ~bus.StallD);
      retire_cnt_d = retire_cnt_q + XLEN'(idex_q.valid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.flush_cnt  = flush_cnt_q;
   assign bus.retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_fd_regs.sv
// Directed bench for pipe_fd_regs with an in-order scoreboard of instructions expected to reach ID/EX.
module tb_pipe_fd_regs;
   import rv32_pipe_pkg::*;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_fd_regs_if bus ();

   pipe_fd_regs dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Stand-in decoder: D-side operands are simple functions of InstrD.
   always_comb begin
      bus.CtrlD   = bus.InstrD[9:0];
      bus.RD1D    = bus.InstrD ^ 32'h5555_5555;
      bus.RD2D    = ~bus.InstrD;
      bus.ImmExtD = bus.InstrD + 32'd1;
      bus.Rs1D    = bus.InstrD[19:15];
      bus.Rs2D    = bus.InstrD[24:20];
      bus.RdD     = bus.InstrD[11:7];
   end

   int  checks = 0;
   int  errors = 0;
   sb_t sb_q[$];
   int  stall_exp  = 0;
   int  flush_exp  = 0;
   int  retire_exp = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      sb_t e;
      if (bus.ValidE === 1'b1) begin
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("PCE", bus.PCE, e.pc);
            chk("PCPlus4E", bus.PCPlus4E, e.pc + 32'd4);
            chk("CtrlE", 32'(bus.CtrlE), 32'(e.instr[9:0]));
            chk("RD1E", bus.RD1E, e.instr ^ 32'h5555_5555);
            chk("RD2E", bus.RD2E, ~e.instr);
            chk("ImmExtE", bus.ImmExtE, e.instr + 32'd1);
            chk("Rs1E", 32'(bus.Rs1E), 32'(e.instr[19:15]));
            chk("Rs2E", 32'(bus.Rs2E), 32'(e.instr[24:20]));
            chk("RdE", 32'(bus.RdE), 32'(e.instr[11:7]));
         end
      end
   endtask

   // One clock: drive controls, note what should retire, clock, then score the E stage.
   task automatic cyc(input logic [31:0] instr, input logic [31:0] tgt,
                      input logic sf, input logic sd, input logic fd, input logic fe,
                      input logic ps, input bit keep);
      bus.InstrF    = instr;
      bus.PCTargetE = tgt;
      bus.StallF    = sf;
      bus.StallD    = sd;
      bus.FlushD    = fd;
      bus.FlushE    = fe;
      bus.PCSrcE    = ps;
      if (keep && !fd && !sd) sb_q.push_back(sb_t'{instr: instr, pc: bus.PCF});
      if (bus.ValidE === 1'b1) retire_exp++;
      if (sd) stall_exp++;
      if (fe && !sd) flush_exp++;
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic chk_d_idle(input string tag);
      chk({tag, "_InstrD"}, bus.InstrD, 32'h0000_0013);
      chk({tag, "_PCD"}, bus.PCD, 32'h0);
      chk({tag, "_PCPlus4D"}, bus.PCPlus4D, 32'h0);
      chk({tag, "_ValidD"}, 32'(bus.ValidD), 32'd0);
   endtask

   logic [31:0] ia, ib, ic, ix, iy;
   logic [31:0] rnd;

   initial begin
      ia = 32'h0000_000A;
      ib = 32'h0000_000B;
      ic = 32'h0000_000C;
      ix = 32'h00A5_8F33;
      iy = 32'h0FF0_1B23;
      rst = 1'b1;
      bus.InstrF = '0; bus.PCTargetE = '0;
      bus.StallF = 1'b0; bus.StallD = 1'b0; bus.FlushD = 1'b0;
      bus.FlushE = 1'b0; bus.PCSrcE = 1'b0;
      #12;
      chk("rst_PCF", bus.PCF, 32'h0);
      chk_d_idle("rst");
      chk("rst_ValidE", 32'(bus.ValidE), 32'd0);
      chk("rst_CtrlE", 32'(bus.CtrlE), 32'd0);
      chk("rst_PCE", bus.PCE, 32'h0);
      chk("rst_RD1E", bus.RD1E, 32'h0);
      rst = 1'b0;

      // Plain stream A, B.
      cyc(ia, 32'h0, 0, 0, 0, 0, 0, 1);
      chk("s1_PCF", bus.PCF, 32'h4);
      chk("s1_InstrD", bus.InstrD, ia);
      chk("s1_PCD", bus.PCD, 32'h0);
      chk("s1_PCPlus4D", bus.PCPlus4D, 32'h4);
      chk("s1_ValidD", 32'(bus.ValidD), 32'd1);
      chk("s1_ValidE", 32'(bus.ValidE), 32'd0);
      cyc(ib, 32'h0, 0, 0, 0, 0, 0, 1);
      chk("s2_PCF", bus.PCF, 32'h8);
      chk("s2_InstrD", bus.InstrD, ib);
      chk("s2_ValidE", 32'(bus.ValidE), 32'd1);
      chk("s2_CtrlE", 32'(bus.CtrlE), 32'h00A);

      // Load-use at PCF=8.
      cyc(ic, 32'h0, 1, 1, 0, 1, 0, 1);
      chk("lu_PCF", bus.PCF, 32'h8);
      chk("lu_InstrD", bus.InstrD, ib);
      chk("lu_ValidE", 32'(bus.ValidE), 32'd0);
      chk("lu_CtrlE", 32'(bus.CtrlE), 32'd0);
      cyc(ic, 32'h0, 0, 0, 0, 0, 0, 1);
      chk("lu2_PCF", bus.PCF, 32'hC);
      chk("lu2_InstrD", bus.InstrD, ic);
      chk("lu2_CtrlE", 32'(bus.CtrlE), 32'h00B);
      cyc(32'h1234_5A93, 32'h0, 0, 0, 0, 0, 0, 0);
      chk("lu3_CtrlE", 32'(bus.CtrlE), 32'h00C);

      // Taken branch to 0x100.
      cyc(32'hDEAD_0001, 32'h100, 0, 0, 1, 1, 1, 0);
      chk("br_PCF", bus.PCF, 32'h100);
      chk_d_idle("br");
      chk("br_CtrlE", 32'(bus.CtrlE), 32'd0);
      chk("br_ValidE", 32'(bus.ValidE), 32'd0);
      cyc(ix, 32'h0, 0, 0, 0, 0, 0, 1);
      chk("br2_PCF", bus.PCF, 32'h104);
      chk("br2_ValidE", 32'(bus.ValidE), 32'd0);

      // Redirect beats StallF; then FlushD beats StallD.
      cyc(iy, 32'h40, 1, 0, 0, 0, 1, 1);
      chk("rw_PCF", bus.PCF, 32'h40);
      chk("rw_PCD", bus.PCD, 32'h104);
      chk("rw_CtrlE", 32'(bus.CtrlE), 32'(ix[9:0]));
      cyc(32'h7777_7777, 32'h0, 0, 1, 1, 0, 0, 0);
      chk("fs_PCF", bus.PCF, 32'h44);
      chk_d_idle("fs");
      chk("fs_ValidE", 32'(bus.ValidE), 32'd1);

      // Reach PCF=0x20, stall there, then assert reset mid-cycle.
      cyc(32'h0000_0001, 32'h20, 0, 0, 1, 1, 1, 0);
      cyc(32'h0000_0002, 32'h0, 1, 1, 0, 0, 0, 0);
      chk("st_PCF", bus.PCF, 32'h20);
      chk("st_CtrlE", 32'(bus.CtrlE), 32'h013);
      #3;
      rst = 1'b1;
      #1;
      sb_q.delete();
      stall_exp = 0; flush_exp = 0; retire_exp = 0;
      chk("ar_PCF", bus.PCF, 32'h0);
      chk_d_idle("ar");
      chk("ar_ValidE", 32'(bus.ValidE), 32'd0);
      chk("ar_CtrlE", 32'(bus.CtrlE), 32'd0);
      @(posedge clk);
      #1;
      chk("ar2_PCF", bus.PCF, 32'h0);
      bus.StallF = 1'b0; bus.StallD = 1'b0;
      rst = 1'b0;
      cyc(32'h0000_0593, 32'h0, 0, 0, 0, 0, 0, 0);
      chk("pr_PCF", bus.PCF, 32'h4);
      chk("pr_PCD", bus.PCD, 32'h0);
      chk("pr_InstrD", bus.InstrD, 32'h0000_0593);

      // PC wrap at 0xFFFF_FFFC.
      cyc(32'h0000_0003, 32'hFFFF_FFFC, 0, 0, 1, 1, 1, 0);
      chk("wr_PCF", bus.PCF, 32'hFFFF_FFFC);
      cyc(32'hCAFE_0F93, 32'h0, 0, 0, 0, 0, 0, 1);
      chk("wr2_PCF", bus.PCF, 32'h0);
      chk("wr2_PCD", bus.PCD, 32'hFFFF_FFFC);
      chk("wr2_PCPlus4D", bus.PCPlus4D, 32'h0);
      cyc(32'h0BAD_1123, 32'h0, 0, 0, 0, 0, 0, 1);
      chk("wr3_PCPlus4E", bus.PCPlus4E, 32'h0);

      // Fresh reset, then 20 cycles: load-use at 3/7/11, branch at 15.
      rst = 1'b1;
      #1;
      sb_q.delete();
      stall_exp = 0; flush_exp = 0; retire_exp = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rnd = $urandom();
         if (i == 3 || i == 7 || i == 11) cyc(rnd, 32'h0, 1, 1, 0, 1, 0, 1);
         else if (i == 15) cyc(rnd, 32'h200, 0, 0, 1, 1, 1, 0);
         else cyc(rnd, 32'h0, 0, 0, 0, 0, 0, (i != 14));
      end
      chk("end_PCF", bus.PCF, 32'h210);
      chk("end_sb_left", 32'(sb_q.size()), 32'd1);
`ifdef PIPE_PERF_CNT_EN
      chk("stall_cnt", bus.stall_cnt, 32'd3);
      chk("flush_cnt", bus.flush_cnt, 32'd1);
      chk("retire_cnt", bus.retire_cnt, 32'(retire_exp));
      chk("stall_cnt_model", bus.stall_cnt, 32'(stall_exp));
      chk("flush_cnt_model", bus.flush_cnt, 32'(flush_exp));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_fd_regs.md
Name: pipe_fd_regs

Overview:
- Receiving end of the hazard-unit stall/flush interface for the 5-stage RV32I core.
- Owns the architectural PC register, the IF/ID pipeline register and the ID/EX pipeline register.
- Applies StallF, StallD, FlushD and FlushE each cycle, with the required priorities.
- Sits between fetch/decode datapath and execute; the hazard unit drives its control inputs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected into IF/ID on flush or reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- StallF  in  1  hold PC
- StallD  in  1  hold IF/ID
- FlushD  in  1  bubble IF/ID
- FlushE  in  1  bubble ID/EX
- PCSrcE  in  1  taken branch/jump in E; redirect PC
- PCTargetE  in  32  redirect target
- InstrF  in  32  fetched instruction
- PCF  out  32  current fetch PC
- InstrD, PCD, PCPlus4D  out  32 each  IF/ID contents
- ValidD  out  1  IF/ID holds a real instruction
- CtrlD  in  10  {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
- RD1D, RD2D, ImmExtD  in  32 each
- Rs1D, Rs2D, RdD  in  5 each
- CtrlE  out  10  registered CtrlD
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each
- Rs1E, Rs2E, RdE  out  5 each
- ValidE  out  1

Behaviour:
- Reset is asynchronous, active-high. While rst=1:
  - PCF=RESET_PC.
  - InstrD=NOP_INSTR; PCD=PCPlus4D=0; ValidD=0.
  - All E outputs=0; ValidE=0.
- PC logic:
  - PCPlus4F = PCF+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Next PC = PCTargetE if PCSrcE, else PCPlus4F.
  - PCF updates every edge unless StallF=1 and PCSrcE=0.
  - PCSrcE overrides StallF so a redirect is never lost.
- IF/ID register, priority FlushD > StallD > load:
  - Flush: InstrD=NOP_INSTR, PCD=PCPlus4D=0, ValidD=0.
  - Stall: all IF/ID fields hold.
  - Load: InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
- ID/EX register (no stall input):
  - FlushE=1: all E fields=0, ValidE=0.
  - Otherwise: load all D-side values; ValidE=ValidD.
  - ResultSrcE of 2'b00 after a flush guarantees the hazard unit sees no load in E.
- Latency: one cycle per stage. An instruction presented at InstrF on edge N appears at InstrD after N and at ID/EX outputs after N+1, absent stalls/flushes.
- Simultaneous events:
  - Load-use (StallF=StallD=FlushE=1): PC and IF/ID hold, E gets a bubble.
  - Branch taken (FlushD=FlushE=1, PCSrcE=1): PC redirects, D and E both get bubbles.
  - StallD=1 with FlushD=1: flush wins.
- Reset mid-stall/flush: reset dominates immediately (async). The first edge after deassertion fetches from RESET_PC.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Enabled: adds three 32-bit outputs:
  - stall_cnt: +1 each cycle StallD=1.
  - flush_cnt: +1 each cycle FlushE=1 and StallD=0, i.e. branch bubbles only.
  - retire_cnt: +1 each cycle ValidE=1.
  - All counters wrap at 2^32, reset to 0, and are cleared by rst.
- Disabled: ports and counters absent; no other behaviour changes.

Decomposition:
- Shared package rv32_pipe_pkg: NOP_INSTR constant, RESET_PC default, CTRL_W=10, and the control-bundle field offsets (RegWrite bit 9 … ALUSrc bit 0).
- One natural sub-module: pipe_reg, a generic width-parameterised register with en and clr, clr over en, async rst to a reset value. Instantiated for PC, IF/ID and ID/EX.

Test Plan:
- Reset, then no stalls, InstrF stream 0xA, 0xB, 0xC → PCF 0, 4, 8, 12. InstrD lags InstrF by one cycle. CtrlE/RdE lag by two. ValidE=1 from cycle 2.
- One-cycle load-use at PCF=8 (StallF=StallD=FlushE=1) → PCF stays 8 and InstrD holds for one cycle. Next cycle CtrlE=0 and ValidE=0, then the stream resumes. No instruction is lost or duplicated.
- PCSrcE=1, PCTargetE=0x100, FlushD=FlushE=1 → next PCF=0x100, InstrD=0x00000013 with ValidD=0, CtrlE=0.
- StallF=1 with PCSrcE=1, PCTargetE=0x40 → PCF=0x40 (redirect wins). StallD=1 with FlushD=1 → InstrD=NOP.
- rst asserted mid-stall with PCF=0x20 → PCF=RESET_PC immediately (before the next edge); all Valid outputs 0. PCF=0xFFFF_FFFC with no stall → wraps to 0.
- With PIPE_PERF_CNT_EN: 3 load-use stalls plus 1 taken branch over 20 cycles → stall_cnt=3, flush_cnt=1, and retire_cnt equals the count of ValidE=1 cycles.
